// File: rtl/consumer_fetch_scheduler_if.sv
// Load-request bus between the fetch scheduler and the MSHR consumer unit.
// The scheduler drives requests; acks return one per completed load, in issue order.
interface consumer_fetch_scheduler_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              ack;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  ack
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output ack
    );
endinterface

// File: rtl/consumer_fetch_scheduler.sv
// Consumer-side load sequencer for a cohort FIFO: issues line loads up to the
// producer tail with bounded outstanding requests and retires them on in-order acks.
module consumer_fetch_scheduler #(
    parameter int ADDR_W          = 64,
    parameter int PTR_W           = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LINE_LOG2       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic [ADDR_W-1:0]             cfg_base_addr,
    input  logic [4:0]                    cfg_depth_log2,
    input  logic                          enable,
    input  logic [PTR_W-1:0]              tail_ptr_i,
    consumer_fetch_scheduler_if.master    ld,
    output logic [PTR_W-1:0]              head_ptr_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [4:0]        depth_log2;
    logic [PTR_W-1:0]  issue_ptr, issue_nxt;
    logic [PTR_W-1:0]  head_ptr, head_nxt;
    logic [CNT_W-1:0]  outstanding, out_nxt;
    logic              req_valid, req_valid_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic              err, err_nxt;
    logic              busy, busy_nxt;

    logic              hs;
    logic              ack_ok;
    logic              ack_bad;
    logic              overflow;
    logic              can_issue;
    logic [PTR_W:0]    depth_size;
    logic [PTR_W-1:0]  idx_mask;
    logic [PTR_W-1:0]  fill;
    logic [PTR_W-1:0]  pending;

    // Issue decisions look at post-handshake pointer/credit values so that a
    // held ready gives one request per cycle.
    always_comb begin
        hs         = req_valid && ld.req_ready;
        ack_ok     = ld.ack && (outstanding != '0);
        ack_bad    = ld.ack && (outstanding == '0);
        depth_size = (PTR_W + 1)'(1) << depth_log2;
        idx_mask   = depth_size[PTR_W-1:0] - PTR_W'(1);
        fill       = tail_ptr_i - head_ptr;
        overflow   = {1'b0, fill} > depth_size;
        issue_nxt  = issue_ptr + PTR_W'(hs);
        head_nxt   = head_ptr + PTR_W'(ack_ok);
        out_nxt    = outstanding + CNT_W'(hs) - CNT_W'(ack_ok);
        pending    = tail_ptr_i - issue_nxt;
        can_issue  = (state == S_RUN) && enable && (pending != '0) &&
                     (out_nxt < CNT_W'(MAX_OUTSTANDING));

        state_nxt = state;
        case (state)
            S_IDLE:  if (enable && !cfg_valid) state_nxt = S_RUN;
            S_RUN:   if (!enable) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (enable)
                    state_nxt = S_RUN;
                else if ((outstanding == '0) && !req_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        req_valid_nxt = req_valid && !ld.req_ready;
        req_addr_nxt  = req_addr;
        if (!req_valid_nxt && can_issue) begin
            req_valid_nxt = 1'b1;
            req_addr_nxt  = base + (ADDR_W'(issue_nxt & idx_mask) << LINE_LOG2);
        end

        err_nxt  = err || ack_bad || overflow;
        busy_nxt = (state_nxt != S_IDLE) || (out_nxt != '0);
    end

    // A config load in IDLE restarts the pointers and clears the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base        <= '0;
            depth_log2  <= '0;
            issue_ptr   <= '0;
            head_ptr    <= '0;
            outstanding <= '0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            issue_ptr   <= issue_nxt;
            head_ptr    <= head_nxt;
            outstanding <= out_nxt;
            req_valid   <= req_valid_nxt;
            req_addr    <= req_addr_nxt;
            err         <= err_nxt;
            busy        <= busy_nxt;
            if ((state == S_IDLE) && cfg_valid) begin
                base       <= cfg_base_addr;
                depth_log2 <= cfg_depth_log2;
                issue_ptr  <= '0;
                head_ptr   <= '0;
                err        <= 1'b0;
            end
        end
    end

    assign ld.req_valid = req_valid;
    assign ld.req_addr  = req_addr;
    assign head_ptr_o   = head_ptr;
    assign busy_o       = busy;
    assign err_o        = err;

endmodule

// File: tb/tb_consumer_fetch_scheduler.sv
// Directed and randomized bench for consumer_fetch_scheduler against a
// transaction-level model of issue/retire pointers and the sticky error.
module tb_consumer_fetch_scheduler;

    localparam int ADDR_W = 64;
    localparam int PTR_W  = 8;   // narrow pointers make wraparound reachable
    localparam int MAXO   = 4;
    localparam int LL     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [4:0]        cfg_depth_log2;
    logic              enable;
    logic [PTR_W-1:0]  tail;
    logic              req_ready;
    logic              ack;
    logic [PTR_W-1:0]  head_ptr_o;
    logic              busy_o;
    logic              err_o;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [PTR_W-1:0]  m_issue;
    logic [PTR_W-1:0]  m_head;
    int                m_out;
    logic              m_err;
    logic [ADDR_W-1:0] m_base;
    int                m_depth;
    int                hs_count;
    int                first_hs_cycle;
    int                last_hs_cycle;
    logic              hold_pending;
    logic [ADDR_W-1:0] hold_addr;
    logic [PTR_W-1:0]  gap;

    always #5 clk = ~clk;

    consumer_fetch_scheduler_if #(.ADDR_W(ADDR_W)) ld ();
    assign ld.req_ready = req_ready;
    assign ld.ack       = ack;

    consumer_fetch_scheduler #(
        .ADDR_W(ADDR_W), .PTR_W(PTR_W), .MAX_OUTSTANDING(MAXO), .LINE_LOG2(LL)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_base_addr(cfg_base_addr),
        .cfg_depth_log2(cfg_depth_log2), .enable(enable), .tail_ptr_i(tail),
        .ld(ld.master), .head_ptr_o(head_ptr_o), .busy_o(busy_o), .err_o(err_o)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Samples at the falling edge, predicts what the next rising edge does.
    task automatic step_cycle();
        logic             hs_now;
        logic             ack_now;
        logic [PTR_W-1:0] fill;
        @(negedge clk);
        cycle++;
        if (rst) begin
            m_issue = '0; m_head = '0; m_out = 0; m_err = 1'b0;
            m_base = '0; m_depth = 0; hold_pending = 1'b0;
        end else begin
            check_output("head_ptr", head_ptr_o, m_head);
            check_output("err", err_o, m_err);
            if (hold_pending) begin
                check_output("hold_valid", ld.req_valid, 1);
                check_output("hold_addr", ld.req_addr, hold_addr);
            end
            hold_pending = ld.req_valid && !req_ready;
            hold_addr    = ld.req_addr;
            if (ld.req_valid) begin
                check_output("credit_limit", m_out < MAXO, 1);
                check_output("not_past_tail", tail != m_issue, 1);
            end
            hs_now  = ld.req_valid && req_ready;
            ack_now = ack && (m_out > 0);
            fill    = tail - m_head;
            if (ack && m_out == 0) m_err = 1'b1;
            if (int'(fill) > (1 << m_depth)) m_err = 1'b1;
            if (hs_now) begin
                check_output("req_addr", ld.req_addr,
                             m_base + 64'((int'(m_issue) % (1 << m_depth)) * 16));
                m_issue++;
                hs_count++;
                if (hs_count == 1) first_hs_cycle = cycle;
                last_hs_cycle = cycle;
            end
            if (ack_now) m_head++;
            m_out = m_out + int'(hs_now) - int'(ack_now);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; req_ready = 1'b0; ack = 1'b0; tail = '0;
        cfg_base_addr = '0; cfg_depth_log2 = '0;
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic configure(input logic [ADDR_W-1:0] base, input int depth);
        cfg_base_addr = base; cfg_depth_log2 = 5'(depth); cfg_valid = 1'b1;
        step_cycle();
        cfg_valid = 1'b0;
        m_base = base; m_depth = depth; m_issue = '0; m_head = '0; m_err = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        hold_pending = 1'b0;
        hs_count = 0; first_hs_cycle = 0; last_hs_cycle = 0;

        $display("[TB] reset values");
        do_reset();
        check_output("rst_req_valid", ld.req_valid, 0);
        check_output("rst_req_addr", ld.req_addr, 0);
        check_output("rst_head", head_ptr_o, 0);
        check_output("rst_busy", busy_o, 0);
        check_output("rst_err", err_o, 0);

        $display("[TB] basic stream");
        configure(64'h1000, 3);
        enable = 1'b1; tail = 8'd3; req_ready = 1'b1; hs_count = 0;
        apply_stimulus(8);
        check_output("basic_count", hs_count, 3);
        check_output("basic_b2b", last_hs_cycle - first_hs_cycle, 2);
        ack = 1'b1; apply_stimulus(3); ack = 1'b0;
        check_output("basic_head", head_ptr_o, 3);
        apply_stimulus(3);
        check_output("basic_idle_valid", ld.req_valid, 0);
        check_output("basic_no_more", hs_count, 3);

        $display("[TB] credit limit");
        do_reset();
        configure(64'h2000, 4);
        enable = 1'b1; tail = 8'd10; req_ready = 1'b1; hs_count = 0;
        apply_stimulus(12);
        check_output("credit_count", hs_count, 4);
        check_output("credit_valid", ld.req_valid, 0);
        check_output("credit_busy", busy_o, 1);
        ack = 1'b1; step_cycle(); ack = 1'b0;
        apply_stimulus(6);
        check_output("credit_one_more", hs_count, 5);
        check_output("credit_valid2", ld.req_valid, 0);

        $display("[TB] backpressure and index wrap");
        do_reset();
        configure(64'h4000, 2);
        enable = 1'b1; tail = 8'd3; req_ready = 1'b1; hs_count = 0;
        apply_stimulus(6);
        ack = 1'b1; apply_stimulus(3); ack = 1'b0;
        req_ready = 1'b0; tail = 8'd5;
        apply_stimulus(6);
        check_output("bp_valid", ld.req_valid, 1);
        check_output("bp_addr", ld.req_addr, 64'h4030);
        req_ready = 1'b1;
        apply_stimulus(4);
        check_output("wrap_count", hs_count, 5);

        $display("[TB] pointer wrap");
        do_reset();
        configure(64'h8000, 3);
        enable = 1'b1; req_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (m_head == 8'hFF && m_out == 0 && !ld.req_valid) break;
            gap = tail - m_head;
            if (tail != 8'hFF && gap < 8'd6) tail++;
            ack = (m_out > 0);
            step_cycle();
        end
        ack = 1'b0;
        check_output("ptrwrap_head_ff", head_ptr_o, 8'hFF);
        hs_count = 0; tail = 8'h01;
        apply_stimulus(5);
        check_output("ptrwrap_count", hs_count, 2);
        ack = 1'b1; apply_stimulus(2); ack = 1'b0;
        step_cycle();
        check_output("ptrwrap_head", head_ptr_o, 8'h01);
        check_output("ptrwrap_err", err_o, 0);

        $display("[TB] drain");
        do_reset();
        configure(64'hA000, 3);
        enable = 1'b1; tail = 8'd2; req_ready = 1'b1; hs_count = 0;
        apply_stimulus(5);
        check_output("drain_count", hs_count, 2);
        enable = 1'b0;
        apply_stimulus(3);
        check_output("drain_busy", busy_o, 1);
        check_output("drain_valid", ld.req_valid, 0);
        ack = 1'b1; step_cycle(); ack = 1'b0;
        step_cycle();
        check_output("drain_busy2", busy_o, 1);
        ack = 1'b1; step_cycle(); ack = 1'b0;
        apply_stimulus(2);
        check_output("drain_idle_busy", busy_o, 0);
        check_output("drain_head", head_ptr_o, 2);

        $display("[TB] errors");
        do_reset();
        ack = 1'b1; step_cycle(); ack = 1'b0;
        check_output("err_ack_idle", err_o, 1);
        check_output("err_ack_head", head_ptr_o, 0);
        do_reset();
        configure(64'hC000, 3);
        tail = 8'd9;
        step_cycle();
        check_output("err_overflow", err_o, 1);
        do_reset();
        configure(64'hE000, 3);
        enable = 1'b1; req_ready = 1'b0; tail = 8'd4;
        apply_stimulus(4);
        check_output("midrun_valid", ld.req_valid, 1);
        do_reset();
        check_output("midrun_rst_valid", ld.req_valid, 0);
        check_output("midrun_rst_addr", ld.req_addr, 0);
        check_output("midrun_rst_busy", busy_o, 0);
        check_output("midrun_rst_err", err_o, 0);
        check_output("midrun_rst_head", head_ptr_o, 0);

        $display("[TB] randomized traffic");
        do_reset();
        configure({$urandom, $urandom} & ~64'hF, int'($urandom_range(1, 7)));
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            req_ready = 1'($urandom % 2);
            ack = (m_out > 0) && ($urandom % 3 == 0);
            gap = tail - m_head;
            if (($urandom % 2 == 1) && (int'(gap) < (1 << m_depth))) tail++;
            step_cycle();
        end
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy_o) break;
            req_ready = 1'b1;
            ack = (m_out > 0);
            step_cycle();
        end
        ack = 1'b0;
        check_output("rand_drained", busy_o, 0);
        check_output("rand_head_eq_issued", head_ptr_o, m_issue);
        check_output("rand_err", err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
